multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. It sequences one shared ALU, one unified instruction/data memory, the IR, the PC and the register file over several cycles per instruction.
- Decodes `opcode` from the IR and drives all datapath mux selects and write enables.
- Its `alu_op` output feeds the existing ALU control decoder: 00 add, 01 sub, 10 funct-decoded, 11 AND.

---
 rtl/multicycle_control_if.sv | 46 ++++
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// mem_ready exists only when MC_MEM_WAIT_EN is defined.
interface multicycle_control_if;
   logic [5:0] opcode;
`ifdef MC_MEM_WAIT_EN
   logic       mem_ready;
`endif
   logic       pc_write;
   logic       branch;
   logic       iord;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       ext_zero;
   logic [1:0] pcsrc;
   logic [1:0] alu_op;
   logic       instr_done;
   logic       illegal_op;
   logic [3:0] state;

   // Controller side
   modport master (
      input  opcode,
`ifdef MC_MEM_WAIT_EN
      input  mem_ready,
`endif
      output pc_write, branch, iord, mem_write, ir_write, reg_write,
             regdst, memtoreg, alusrca, alusrcb, ext_zero, pcsrc,
             alu_op, instr_done, illegal_op, state
   );

   // Datapath side
   modport slave (
      output opcode,
`ifdef MC_MEM_WAIT_EN
      output mem_ready,
`endif
      input  pc_write, branch, iord, mem_write, ir_write, reg_write,
             regdst, memtoreg, alusrca, alusrcb, ext_zero, pcsrc,
             alu_op, instr_done, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore outputs).
// Optional MC_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module multicycle_control #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      IMMWB    = 4'd10,
      ANDIEX   = 4'd11,
      JUMP     = 4'd12,
      UNUSED13 = 4'd13,
      UNUSED14 = 4'd14,
      UNUSED15 = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q;
   state_t state_d;
   logic   ready;

`ifdef MC_MEM_WAIT_EN
   assign ready = bus.mem_ready;
`else
   assign ready = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= state_t'(RESET_STATE);
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = ready ? DECODE : FETCH;
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_ANDI:      state_d = ANDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = ready ? MEMWB : MEMRD;
         MEMWR:   state_d = ready ? FETCH : MEMWR;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = IMMWB;
         ANDIEX:  state_d = IMMWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      bus.pc_write   = 1'b0;
      bus.branch     = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.ext_zero   = 1'b0;
      bus.pcsrc      = 2'b00;
      bus.alu_op     = 2'b00;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
      bus.state      = state_q;
      case (state_q)
         FETCH: begin
            bus.ir_write = ready;
            bus.pc_write = ready;
            bus.alusrcb  = 2'b01;
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_J: ;
               default: begin
                  bus.illegal_op = 1'b1;
                  bus.instr_done = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         MEMRD: bus.iord = 1'b1;
         MEMWB: begin
            bus.memtoreg   = 1'b1;
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         MEMWR: begin
            bus.iord       = 1'b1;
            bus.mem_write  = 1'b1;
            bus.instr_done = ready;
         end
         EXECUTE: begin
            bus.alusrca = 1'b1;
            bus.alu_op  = 2'b10;
         end
         ALUWB: begin
            bus.regdst     = 1'b1;
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alu_op     = 2'b01;
            bus.pcsrc      = 2'b01;
            bus.branch     = 1'b1;
            bus.instr_done = 1'b1;
         end
         ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         IMMWB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         ANDIEX: begin
            bus.alusrca  = 1'b1;
            bus.alusrcb  = 2'b10;
            bus.ext_zero = 1'b1;
            bus.alu_op   = 2'b11;
         end
         JUMP: begin
            bus.pcsrc      = 2'b10;
            bus.pc_write   = 1'b1;
            bus.instr_done = 1'b1;
         end
         default: ;
      endcase
      // Reset masks the current state's decode: FETCH selects, no enables or pulses.
      if (reset) begin
         bus.pc_write   = 1'b0;
         bus.branch     = 1'b0;
         bus.iord       = 1'b0;
         bus.mem_write  = 1'b0;
         bus.ir_write   = 1'b0;
         bus.reg_write  = 1'b0;
         bus.regdst     = 1'b0;
         bus.memtoreg   = 1'b0;
         bus.alusrca    = 1'b0;
         bus.alusrcb    = 2'b01;
         bus.ext_zero   = 1'b0;
         bus.pcsrc      = 2'b00;
         bus.alu_op     = 2'b00;
         bus.instr_done = 1'b0;
         bus.illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected control
// word per cycle, a negedge monitor pops and compares. Covers MC_MEM_WAIT_EN too.
module tb_multicycle_control;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       ext_zero;
      logic [1:0] pcsrc;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
      logic [3:0] state;
   } ctrl_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control #(.RESET_STATE(4'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ctrl_t exp_q[$];
   int unsigned compared = 0;
   int unsigned mismatched = 0;

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                        6'b001000, 6'b001100, 6'b000010};
   endfunction

   // Instruction walk as listed in the state table: number of states and the i-th one.
   function automatic int unsigned path_len(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011, 6'b000000, 6'b001000, 6'b001100: return 4;
         6'b000100, 6'b000010: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int unsigned path_state(input logic [5:0] op, input int unsigned i);
      int unsigned seq[5];
      seq = '{0, 1, 0, 0, 0};
      case (op)
         6'b100011: seq = '{0, 1, 2, 3, 4};
         6'b101011: seq = '{0, 1, 2, 5, 0};
         6'b000000: seq = '{0, 1, 6, 7, 0};
         6'b001000: seq = '{0, 1, 9, 10, 0};
         6'b001100: seq = '{0, 1, 11, 10, 0};
         6'b000100: seq = '{0, 1, 8, 0, 0};
         6'b000010: seq = '{0, 1, 12, 0, 0};
         default:   ;
      endcase
      return seq[i];
   endfunction

   function automatic ctrl_t spec_out(input int unsigned st, input bit ready,
                                      input bit rst, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      c.state = st[3:0];
      if (rst) begin
         c.alusrcb = 2'b01;
         return c;
      end
      case (st)
         0:  begin c.ir_write = ready; c.pc_write = ready; c.alusrcb = 2'b01; end
         1:  begin
                c.alusrcb = 2'b11;
                if (!is_legal(op)) begin c.illegal_op = 1'b1; c.instr_done = 1'b1; end
             end
         2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         3:  c.iord = 1'b1;
         4:  begin c.memtoreg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
         5:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = ready; end
         6:  begin c.alusrca = 1'b1; c.alu_op = 2'b10; end
         7:  begin c.regdst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
         8:  begin
                c.alusrca = 1'b1; c.alu_op = 2'b01; c.pcsrc = 2'b01;
                c.branch = 1'b1; c.instr_done = 1'b1;
             end
         9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         10: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
         11: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.ext_zero = 1'b1; c.alu_op = 2'b11; end
         12: begin c.pcsrc = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // Called at posedge+1: drive this cycle's inputs, queue its expected word, advance.
   task automatic run_cycle(input int unsigned st, input bit ready, input bit rst);
      reset = rst;
`ifdef MC_MEM_WAIT_EN
      bus.mem_ready = ready;
`endif
      exp_q.push_back(spec_out(st, ready, rst, bus.opcode));
      @(posedge clk);
      #1;
   endtask

   // memwr_wait < 0 picks random stall counts; otherwise forces the MEMWR stall.
   task automatic do_instr(input logic [5:0] op, input int memwr_wait);
      int unsigned st;
      int unsigned w;
      bus.opcode = op;
      for (int unsigned i = 0; i < path_len(op); i++) begin
         st = path_state(op, i);
`ifdef MC_MEM_WAIT_EN
         if (st == 0 || st == 3 || st == 5) begin
            w = $urandom_range(0, 2);
            if (st == 5 && memwr_wait >= 0) w = memwr_wait;
            repeat (w) run_cycle(st, 1'b0, 1'b0);
         end
`else
         w = (memwr_wait < 0) ? 0 : 0;
`endif
         run_cycle(st, 1'b1, 1'b0);
      end
   endtask

   always @(negedge clk) begin
      ctrl_t a;
      ctrl_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.pc_write   = bus.pc_write;
         a.branch     = bus.branch;
         a.iord       = bus.iord;
         a.mem_write  = bus.mem_write;
         a.ir_write   = bus.ir_write;
         a.reg_write  = bus.reg_write;
         a.regdst     = bus.regdst;
         a.memtoreg   = bus.memtoreg;
         a.alusrca    = bus.alusrca;
         a.alusrcb    = bus.alusrcb;
         a.ext_zero   = bus.ext_zero;
         a.pcsrc      = bus.pcsrc;
         a.alu_op     = bus.alu_op;
         a.instr_done = bus.instr_done;
         a.illegal_op = bus.illegal_op;
         a.state      = bus.state;
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL ctrl_word t=%0t op=%b: got %h (state %0d) expected %h (state %0d)",
                     $time, bus.opcode, a, a.state, e, e.state);
         end
      end
   end

   logic [5:0] legal_ops [7];
   logic [5:0] op;

   initial begin
      legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                    6'b001000, 6'b001100, 6'b000010};
      bus.opcode = 6'b000000;
`ifdef MC_MEM_WAIT_EN
      bus.mem_ready = 1'b1;
`endif
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_cycle(0, 1'b1, 1'b1);

      // Directed walks
      do_instr(6'b100011, -1);
      do_instr(6'b001100, -1);
      do_instr(6'b000100, -1);
      do_instr(6'b000010, -1);
      do_instr(6'b111111, -1);
      do_instr(6'b101011, 3);

      // Reset for two cycles starting in ALUWB
      bus.opcode = 6'b000000;
      run_cycle(0, 1'b1, 1'b0);
      run_cycle(1, 1'b1, 1'b0);
      run_cycle(6, 1'b1, 1'b0);
      run_cycle(7, 1'b1, 1'b1);
      run_cycle(0, 1'b1, 1'b1);
      do_instr(6'b001000, -1);

`ifdef MC_MEM_WAIT_EN
      // Reset overriding a MEMWR wait
      bus.opcode = 6'b101011;
      run_cycle(0, 1'b1, 1'b0);
      run_cycle(1, 1'b1, 1'b0);
      run_cycle(2, 1'b1, 1'b0);
      run_cycle(5, 1'b0, 1'b0);
      run_cycle(5, 1'b0, 1'b1);
      run_cycle(0, 1'b0, 1'b0);
      run_cycle(0, 1'b1, 1'b0);
      run_cycle(1, 1'b1, 1'b0);
      run_cycle(2, 1'b1, 1'b0);
      run_cycle(5, 1'b1, 1'b0);
`endif

      // Random mix, mostly legal opcodes
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 4) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(0, 6)];
         do_instr(op, -1);
      end

      @(negedge clk);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
